// File: rtl/series_adder_arbiter.sv
// series_adder_arbiter
//   Round-robin front end that lets N_REQ requesters share one
//   series_adder_data_streamer. It runs one transaction at a time: it picks a
//   requester, captures its M-word vector, issues the vector to the streamer,
//   waits for the sum, and returns the sum tagged with the requester id.
//
//   Optional feature: define SA_ARB_TIMEOUT_EN to bound the WAIT state to
//   TIMEOUT cycles. An expired wait returns resp_err=1 with resp_result=0.
//
//   Handshake rules:
//     Requesters hold req_vld[k] and their req_data lane stable until they see
//     req_ack[k]. If req_vld[k] is still high after the ack, that is a new
//     request. Toward the streamer, a grant happens only in IDLE while
//     sa_data_rdy is high. sa_data_vld is then a single-cycle pulse carrying
//     sa_data_o. sa_result_vld is a single-cycle pulse that is honoured only
//     in WAIT.
module series_adder_arbiter #(
  parameter int N_REQ   = 4,
  parameter int M       = 8,
  parameter int DW      = 32,
  parameter int RW      = 40,
  parameter int TIMEOUT = 256,
  localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_vld,
  input  logic [N_REQ*M*DW-1:0] req_data,
  output logic [N_REQ-1:0]      req_ack,
  output logic                  resp_vld,
  output logic [IDW-1:0]        resp_id,
  output logic [RW-1:0]         resp_result,
`ifdef SA_ARB_TIMEOUT_EN
  output logic                  resp_err,
`endif
  output logic                  busy,
  output logic                  sa_data_vld,
  output logic [M*DW-1:0]       sa_data_o,
  input  logic                  sa_data_rdy,
  input  logic [RW-1:0]         sa_result_i,
  input  logic                  sa_result_vld
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state;
  logic [IDW-1:0]        ptr;
  logic                  grant_found;
  logic [IDW-1:0]        grant_idx;
  logic [M*DW-1:0]       grant_vec;
  logic [N_REQ-1:0]      ack_onehot;
  logic [IDW-1:0]        ptr_next;

`ifdef SA_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0]         to_cnt;
`else
  // Without the timeout the parameter is intentionally left without a function.
  logic                  unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Round-robin pick: the first pending requester at or after ptr, wrapping around.
  always_comb begin : rr_pick
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_vec   = '0;
    ack_onehot  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!grant_found && req_vld[idx]) begin
        grant_found     = 1'b1;
        grant_idx       = IDW'(idx);
        grant_vec       = req_data[idx*M*DW +: M*DW];
        ack_onehot      = '0;
        ack_onehot[idx] = 1'b1;
      end
    end
  end

  // The pointer moves to the requester just after the one being served.
  // With a single requester this keeps the pointer at 0.
  assign ptr_next = (resp_id == IDW'(N_REQ - 1)) ? '0 : resp_id + 1'b1;

  // Transaction FSM. Every output is a register written here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      req_ack     <= '0;
      resp_vld    <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
      busy        <= 1'b0;
      sa_data_vld <= 1'b0;
      sa_data_o   <= '0;
`ifdef SA_ARB_TIMEOUT_EN
      resp_err    <= 1'b0;
      to_cnt      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (sa_data_rdy && grant_found) begin
            sa_data_o   <= grant_vec;
            resp_id     <= grant_idx;
            req_ack     <= ack_onehot;
            sa_data_vld <= 1'b1;
            busy        <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          req_ack     <= '0;
          sa_data_vld <= 1'b0;
          ptr         <= ptr_next;
`ifdef SA_ARB_TIMEOUT_EN
          to_cnt      <= '0;
`endif
          state       <= S_WAIT;
        end
        S_WAIT: begin
`ifdef SA_ARB_TIMEOUT_EN
          if (sa_result_vld) begin
            resp_result <= sa_result_i;
            resp_err    <= 1'b0;
            resp_vld    <= 1'b1;
            state       <= S_RESP;
          end else if (to_cnt == TO_LAST) begin
            resp_result <= '0;
            resp_err    <= 1'b1;
            resp_vld    <= 1'b1;
            state       <= S_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`else
          if (sa_result_vld) begin
            resp_result <= sa_result_i;
            resp_vld    <= 1'b1;
            state       <= S_RESP;
          end
`endif
        end
        S_RESP: begin
          resp_vld <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_series_adder_arbiter.sv
// Directed bench for series_adder_arbiter. A small streamer model answers each
// sa_data_vld pulse with the sum of the issued vector after stream_lat cycles.
// A monitor logs acks and responses so they can be compared with the
// expected queues.
module tb_series_adder_arbiter;
  localparam int N_REQ = 4;
  localparam int M     = 8;
  localparam int DW    = 32;
  localparam int RW    = 40;
  localparam int IDW   = 2;
  localparam int VW    = M * DW;

  logic                  clk;
  logic                  rst_n;
  logic [N_REQ-1:0]      req_vld;
  logic [N_REQ*VW-1:0]   req_data;
  logic [N_REQ-1:0]      req_ack;
  logic                  resp_vld;
  logic [IDW-1:0]        resp_id;
  logic [RW-1:0]         resp_result;
  logic                  busy;
  logic                  sa_data_vld;
  logic [VW-1:0]         sa_data_o;
  logic                  sa_data_rdy;
  logic [RW-1:0]         sa_result_i;
  logic                  sa_result_vld;
`ifdef SA_ARB_TIMEOUT_EN
  logic                  resp_err;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int stream_lat = 2;
  bit stream_en  = 1'b1;
  int dvld_cnt   = 0;

  logic [N_REQ-1:0]      ack_q[$];
  logic [IDW+RW-1:0]     resp_q[$];
  logic [IDW+RW-1:0]     exp_q[$];
  logic [N_REQ-1:0]      exp_ack_q[$];

  series_adder_arbiter #(
    .N_REQ(N_REQ), .M(M), .DW(DW), .RW(RW), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_data(req_data), .req_ack(req_ack),
    .resp_vld(resp_vld), .resp_id(resp_id), .resp_result(resp_result),
`ifdef SA_ARB_TIMEOUT_EN
    .resp_err(resp_err),
`endif
    .busy(busy), .sa_data_vld(sa_data_vld), .sa_data_o(sa_data_o),
    .sa_data_rdy(sa_data_rdy), .sa_result_i(sa_result_i),
    .sa_result_vld(sa_result_vld)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] mk_vec(input int base);
    logic [VW-1:0] v;
    v = '0;
    for (int j = 0; j < M; j++) v[j*DW +: DW] = DW'(base + j * 3 + 1);
    return v;
  endfunction

  function automatic logic [RW-1:0] sum_vec(input logic [VW-1:0] v);
    logic [RW-1:0] s;
    s = '0;
    for (int j = 0; j < M; j++) s = s + RW'(v[j*DW +: DW]);
    return s;
  endfunction

  task automatic set_lane(input int k, input logic [VW-1:0] v);
    req_data[k*VW +: VW] = v;
  endtask

  // Leaves the caller at the negedge of the n-th ack cycle.
  task automatic wait_acks(input string tag, input int n, input int budget);
    int seen;
    seen = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      @(negedge clk);
      if (req_ack != '0) seen++;
    end
    check(tag, seen, n);
  endtask

  task automatic wait_resp(input string tag, input int n, input int budget);
    for (int c = 0; c < budget && resp_q.size() < n; c++) @(negedge clk);
    check(tag, resp_q.size(), n);
  endtask

  task automatic clear_logs();
    ack_q.delete();
    resp_q.delete();
    exp_q.delete();
    exp_ack_q.delete();
    dvld_cnt = 0;
  endtask

  task automatic score(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < resp_q.size()) begin
        check({tag, "_id"}, resp_q[i][IDW+RW-1:RW], exp_q[i][IDW+RW-1:RW]);
        check({tag, "_sum"}, resp_q[i][RW-1:0], exp_q[i][RW-1:0]);
      end
    end
    for (int i = 0; i < exp_ack_q.size(); i++) begin
      if (i < ack_q.size()) check({tag, "_ack"}, ack_q[i], exp_ack_q[i]);
    end
  endtask

  // ---------------- streamer model ----------------
  initial begin
    logic [RW-1:0] s;
    sa_result_vld = 1'b0;
    sa_result_i   = '0;
    forever begin
      @(negedge clk);
      sa_result_vld = 1'b0;
      if (sa_data_vld && stream_en) begin
        s = sum_vec(sa_data_o);
        repeat (stream_lat) @(negedge clk);
        sa_result_i   = s;
        sa_result_vld = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ack != '0) ack_q.push_back(req_ack);
      if (sa_data_vld) dvld_cnt++;
      if (resp_vld) resp_q.push_back({resp_id, resp_result});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [VW-1:0] v1;
    logic [VW-1:0] lanes[N_REQ];
    int cyc;

    rst_n       = 1'b0;
    req_vld     = '0;
    req_data    = '0;
    sa_data_rdy = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ack", req_ack, 0);
    check("rst_resp_vld", resp_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_dvld", sa_data_vld, 0);
    check("rst_data_zero", (sa_data_o == '0), 1);
    check("rst_result", resp_result, 0);
    check("rst_id", resp_id, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: single request on lane 2.
    clear_logs();
    v1 = '0;
    v1[0*DW +: DW] = 32'd20000;
    v1[1*DW +: DW] = 32'd100000;
    for (int j = 2; j < M; j++) v1[j*DW +: DW] = 32'd1000000;
    set_lane(2, v1);
    req_vld = 4'b0100;
    wait_acks("t1_ack_seen", 1, 20);
    check("t1_ack", req_ack, 4'b0100);
    check("t1_dvld", sa_data_vld, 1);
    check("t1_busy", busy, 1);
    check("t1_vec", (sa_data_o == v1), 1);
    req_vld = '0;
    wait_resp("t1_resp_seen", 1, 30);
    if (resp_q.size() > 0) begin
      check("t1_id", resp_q[0][IDW+RW-1:RW], 2);
      check("t1_sum", resp_q[0][RW-1:0], 40'd6120000);
    end
`ifdef SA_ARB_TIMEOUT_EN
    check("t1_err", resp_err, 0);
`endif
    repeat (2) @(negedge clk);
    check("t1_dvld_count", dvld_cnt, 1);
    check("t1_idle", busy, 0);

    // Test 2: all four requesting, the pointer restarts at 0 after reset.
    do_reset();
    clear_logs();
    for (int k = 0; k < N_REQ; k++) begin
      lanes[k] = mk_vec(1000 + k * 100);
      set_lane(k, lanes[k]);
    end
    exp_ack_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_q.push_back({2'd0, sum_vec(lanes[0])});
    exp_q.push_back({2'd1, sum_vec(lanes[1])});
    exp_q.push_back({2'd2, sum_vec(lanes[2])});
    exp_q.push_back({2'd3, sum_vec(lanes[3])});
    exp_q.push_back({2'd0, sum_vec(lanes[0])});
    req_vld = 4'b1111;
    wait_acks("t2_acks", 5, 100);
    req_vld = '0;
    wait_resp("t2_resps", 5, 30);
    score("t2");

    // Test 3: requesters 0 and 3 alternate.
    do_reset();
    clear_logs();
    for (int k = 0; k < N_REQ; k++) begin
      lanes[k] = mk_vec(5000 + k * 37);
      set_lane(k, lanes[k]);
    end
    exp_ack_q = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
    exp_q.push_back({2'd0, sum_vec(lanes[0])});
    exp_q.push_back({2'd3, sum_vec(lanes[3])});
    exp_q.push_back({2'd0, sum_vec(lanes[0])});
    exp_q.push_back({2'd3, sum_vec(lanes[3])});
    req_vld = 4'b1001;
    wait_acks("t3_acks", 4, 100);
    req_vld = '0;
    wait_resp("t3_resps", 4, 30);
    score("t3");

    // Test 4: streamer not ready blocks the grant.
    repeat (2) @(negedge clk);
    clear_logs();
    sa_data_rdy = 1'b0;
    req_vld = 4'b0010;
    cyc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ack != '0 || busy) cyc++;
    end
    check("t4_blocked", cyc, 0);
    sa_data_rdy = 1'b1;
    @(negedge clk);
    check("t4_ack", req_ack, 4'b0010);
    check("t4_dvld", sa_data_vld, 1);
    req_vld = '0;
    wait_resp("t4_resp_seen", 1, 30);
    if (resp_q.size() > 0) check("t4_id", resp_q[0][IDW+RW-1:RW], 1);

    // Test 5: reset during WAIT; a late stray result must be ignored.
    repeat (2) @(negedge clk);
    clear_logs();
    stream_lat = 12;
    req_vld = 4'b0100;
    wait_acks("t5_ack_seen", 1, 20);
    req_vld = '0;
    repeat (3) @(negedge clk);
    check("t5_busy_wait", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_resp_vld", resp_vld, 0);
    check("t5_rst_data_zero", (sa_data_o == '0), 1);
    check("t5_rst_result", resp_result, 0);
    check("t5_rst_id", resp_id, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("t5_no_resp", resp_q.size(), 0);
    check("t5_idle", busy, 0);
    stream_lat = 2;
    lanes[1] = mk_vec(777);
    lanes[3] = mk_vec(888);
    set_lane(1, lanes[1]);
    set_lane(3, lanes[3]);
    req_vld = 4'b1010;
    wait_acks("t5_ack2_seen", 1, 20);
    check("t5_ack2", req_ack, 4'b0010);
    req_vld = '0;
    wait_resp("t5_resp_seen", 1, 30);
    if (resp_q.size() > 0) begin
      check("t5_id", resp_q[0][IDW+RW-1:RW], 1);
      check("t5_sum", resp_q[0][RW-1:0], sum_vec(lanes[1]));
    end

`ifdef SA_ARB_TIMEOUT_EN
    // Test 6: the streamer never answers; the response comes 16 cycles after WAIT entry.
    repeat (2) @(negedge clk);
    clear_logs();
    stream_en = 1'b0;
    req_vld = 4'b0001;
    wait_acks("t6_ack_seen", 1, 20);
    req_vld = '0;
    cyc = 0;
    for (int c = 0; c < 40 && !resp_vld; c++) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_latency", cyc, 17);
    check("t6_resp_vld", resp_vld, 1);
    check("t6_err", resp_err, 1);
    check("t6_result", resp_result, 0);
    check("t6_id", resp_id, 0);
    @(negedge clk);
    check("t6_idle", busy, 0);
    stream_en = 1'b1;
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
